multicycle_controller: RTL and testbench
========================================

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 op  input  7  opcode of the instruction register.
REQ-005 funct3  input  3  funct3 of the instruction register.
REQ-006 funct7b5  input  1  instruction bit 30.
REQ-007 ZeroF  input  1  ALU zero flag.
REQ-008 SignF  input  1  ALU sign flag.
REQ-009 mem_ready  input  1  memory completes the current access this cycle.
REQ-010 mem_req  output  1  memory access request.
REQ-011 AdrSrc  output  1  memory address select: 0 = PC, 1 = ALUOut.
REQ-012 IRWrite  output  1  load the instruction register and OldPC.
REQ-013 PCWrite  output  1  load the PC from the result bus.
REQ-014 MemWrite  output  1  the access is a write.
REQ-015 RegWrite  output  1  register file write enable.
REQ-016 ResultSrc  output  2  result select: 00 = ALUOut, 01 = read data, 10 = ALU result.
REQ-017 ALUSrcA  output  2  ALU A operand: 00 = PC, 01 = OldPC, 10 = rs1.
REQ-018 ALUSrcB  output  2  ALU B operand: 00 = rs2, 01 = imm, 10 = constant 4.
REQ-019 ImmSrc  output  2  immediate format: 00 = I, 01 = S, 10 = B.
REQ-020 ALUControl  output  3  ALU operation.
REQ-021 state  output  4  current FSM state, for debug.
REQ-022 illegal_op  output  1  one-cycle pulse on an unsupported opcode.

Function
REQ-023 The FSM SHALL have the states FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, ALUWB=8 and BRANCH=9.
REQ-024 Any output not listed for a state SHALL be 0.
REQ-025 FETCH: mem_req=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ResultSrc=10; IRWrite and PCWrite both equal mem_ready; the FSM stays in FETCH until mem_ready=1, then moves to DECODE.
REQ-026 DECODE: ALUSrcA=01, ALUSrcB=01, ALUControl=000 (branch target into ALUOut).
REQ-027 DECODE next state: 0000011 or 0100011 -> MEMADR; 0110011 -> EXECR; 0010011 -> EXECI; 1100011 -> BRANCH; any other opcode -> FETCH with illegal_op=1 for that cycle and no write strobes.
REQ-028 MEMADR: ALUSrcA=10, ALUSrcB=01, ALUControl=000; next state is MEMREAD if op[5]=0, MEMWRITE if op[5]=1.
REQ-029 MEMREAD: mem_req=1, AdrSrc=1; the FSM holds until mem_ready=1, then moves to MEMWB.
REQ-030 MEMWB: ResultSrc=01, RegWrite=1, then FETCH.
REQ-031 MEMWRITE: mem_req=1, AdrSrc=1, MemWrite=1, held stable until mem_ready=1, then FETCH.
REQ-032 EXECR: ALUSrcA=10, ALUSrcB=00, then ALUWB.
REQ-033 EXECI: ALUSrcA=10, ALUSrcB=01, then ALUWB.
REQ-034 ALUWB: ResultSrc=00, RegWrite=1, then FETCH.
REQ-035 BRANCH: ALUSrcA=10, ALUSrcB=00, ALUControl=010, ResultSrc=00, then FETCH.
REQ-036 In BRANCH, PCWrite SHALL be ZeroF for funct3=000, ~ZeroF for funct3=001, SignF for funct3=100, and 0 for any other funct3.
REQ-037 In EXECR and EXECI, ALUControl SHALL be derived from funct3 as follows:
- funct3=000: 010 if op[5]&funct7b5 = 1, else 000;
- funct3=001: 001;
- funct3=100..111: equal to funct3;
- funct3=010 or 011: equal to funct3.
REQ-038 ImmSrc SHALL be decoded combinationally from op in every state: 0100011 -> 01, 1100011 -> 10, otherwise 00.
REQ-039 All outputs SHALL be combinational functions of state and inputs (Mealy only for IRWrite, PCWrite and illegal_op); no output is registered.
REQ-040 Instruction latency with mem_ready held at 1 SHALL be: load 5 cycles; store, R-type and I-type 4 cycles; branch 3 cycles.
REQ-041 Each cycle with mem_ready=0 in FETCH, MEMREAD or MEMWRITE SHALL add exactly one cycle of latency, with all outputs held unchanged.
REQ-042 mem_ready SHALL be ignored in every state other than FETCH, MEMREAD and MEMWRITE.

Reset
REQ-043 When rst_n=0, state SHALL go to FETCH immediately regardless of clk, including mid-access.
REQ-044 While in reset, all write strobes (IRWrite, PCWrite, MemWrite, RegWrite) SHALL be forced to 0 and mem_req SHALL be forced to 0.
REQ-045 The first FETCH cycle SHALL begin on the first rising clk after rst_n deasserts.

Verification
REQ-046 Reset: assert rst_n=0 mid-cycle -> state=0 and all strobes 0 without waiting for a clock edge; release rst_n -> FETCH with mem_req=1.
REQ-047 Load, op=0000011, with mem_ready low for 2 cycles in FETCH and 1 cycle in MEMREAD -> 8 cycles total; RegWrite=1 with ResultSrc=01 only in MEMWB.
REQ-048 R-type sub, op=0110011, funct3=000, funct7b5=1 -> ALUControl=010 in EXECR; the same encoding with op=0010011 -> 000.
REQ-049 Branch, op=1100011:
- funct3=000, ZeroF=1 -> PCWrite=1 in BRANCH;
- funct3=001, ZeroF=1 -> PCWrite=0;
- funct3=100, SignF=1 -> PCWrite=1;
- funct3=110 -> PCWrite=0.
REQ-050 Store held in MEMWRITE with mem_ready=0, then rst_n pulsed low -> MemWrite drops to 0 immediately and state returns to 0.
REQ-051 Opcode 1111111 -> illegal_op=1 for exactly one cycle in DECODE, no strobes asserted, next state FETCH.

Source files
------------

// File: rtl/multicycle_controller.sv
// Multicycle RISC-V style main controller: ten-state FSM sequencing fetch, decode,
// memory, ALU and branch steps, with a ready handshake on every memory access.
module multicycle_controller (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [6:0] op,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic       ZeroF,
   input  logic       SignF,
   input  logic       mem_ready,
   output logic       mem_req,
   output logic       AdrSrc,
   output logic       IRWrite,
   output logic       PCWrite,
   output logic       MemWrite,
   output logic       RegWrite,
   output logic [1:0] ResultSrc,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ImmSrc,
   output logic [2:0] ALUControl,
   output logic [3:0] state,
   output logic       illegal_op
);

   typedef enum logic [3:0] {
      FETCH    = 4'd0,
      DECODE   = 4'd1,
      MEMADR   = 4'd2,
      MEMREAD  = 4'd3,
      MEMWB    = 4'd4,
      MEMWRITE = 4'd5,
      EXECR    = 4'd6,
      EXECI    = 4'd7,
      ALUWB    = 4'd8,
      BRANCH   = 4'd9
   } state_t;

   state_t     cur, nxt;
   logic       req, irw, pcw, mw, rw;
   logic [2:0] alu_op;
   logic       br_take;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cur <= FETCH;
      else        cur <= nxt;
   end

   always_comb begin
      alu_op = funct3;
      if (funct3 == 3'b000) alu_op = (op[5] & funct7b5) ? 3'b010 : 3'b000;
   end

   always_comb begin
      case (funct3)
         3'b000:  br_take = ZeroF;
         3'b001:  br_take = ~ZeroF;
         3'b100:  br_take = SignF;
         default: br_take = 1'b0;
      endcase
   end

   always_comb begin
      case (op)
         7'b0100011: ImmSrc = 2'b01;
         7'b1100011: ImmSrc = 2'b10;
         default:    ImmSrc = 2'b00;
      endcase
   end

   always_comb begin
      nxt        = cur;
      req        = 1'b0;
      irw        = 1'b0;
      pcw        = 1'b0;
      mw         = 1'b0;
      rw         = 1'b0;
      AdrSrc     = 1'b0;
      ResultSrc  = 2'b00;
      ALUSrcA    = 2'b00;
      ALUSrcB    = 2'b00;
      ALUControl = 3'b000;
      illegal_op = 1'b0;
      case (cur)
         FETCH: begin
            req       = 1'b1;
            ALUSrcB   = 2'b10;
            ResultSrc = 2'b10;
            irw       = mem_ready;
            pcw       = mem_ready;
            if (mem_ready) nxt = DECODE;
         end
         DECODE: begin
            ALUSrcA = 2'b01;
            ALUSrcB = 2'b01;
            case (op)
               7'b0000011, 7'b0100011: nxt = MEMADR;
               7'b0110011:             nxt = EXECR;
               7'b0010011:             nxt = EXECI;
               7'b1100011:             nxt = BRANCH;
               default: begin
                  nxt        = FETCH;
                  illegal_op = 1'b1;
               end
            endcase
         end
         MEMADR: begin
            ALUSrcA = 2'b10;
            ALUSrcB = 2'b01;
            nxt     = op[5] ? MEMWRITE : MEMREAD;
         end
         MEMREAD: begin
            req    = 1'b1;
            AdrSrc = 1'b1;
            if (mem_ready) nxt = MEMWB;
         end
         MEMWB: begin
            ResultSrc = 2'b01;
            rw        = 1'b1;
            nxt       = FETCH;
         end
         MEMWRITE: begin
            req    = 1'b1;
            AdrSrc = 1'b1;
            mw     = 1'b1;
            if (mem_ready) nxt = FETCH;
         end
         EXECR: begin
            ALUSrcA    = 2'b10;
            ALUControl = alu_op;
            nxt        = ALUWB;
         end
         EXECI: begin
            ALUSrcA    = 2'b10;
            ALUSrcB    = 2'b01;
            ALUControl = alu_op;
            nxt        = ALUWB;
         end
         ALUWB: begin
            rw  = 1'b1;
            nxt = FETCH;
         end
         BRANCH: begin
            ALUSrcA    = 2'b10;
            ALUControl = 3'b010;
            pcw        = br_take;
            nxt        = FETCH;
         end
         default: nxt = FETCH;
      endcase
   end

   // Reset is asynchronous, so strobes are gated directly by rst_n rather than waiting on the register.
   assign mem_req  = req & rst_n;
   assign IRWrite  = irw & rst_n;
   assign PCWrite  = pcw & rst_n;
   assign MemWrite = mw & rst_n;
   assign RegWrite = rw & rst_n;
   assign state    = cur;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: per-cycle vector table plus reset corner sequences.
module tb_multicycle_controller;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [6:0] op;
   logic [2:0] funct3;
   logic       funct7b5, ZeroF, SignF, mem_ready;
   logic       mem_req, AdrSrc, IRWrite, PCWrite, MemWrite, RegWrite, illegal_op;
   logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
   logic [2:0] ALUControl;
   logic [3:0] state;

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;

   multicycle_controller dut (
      .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7b5(funct7b5),
      .ZeroF(ZeroF), .SignF(SignF), .mem_ready(mem_ready), .mem_req(mem_req),
      .AdrSrc(AdrSrc), .IRWrite(IRWrite), .PCWrite(PCWrite), .MemWrite(MemWrite),
      .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
      .ImmSrc(ImmSrc), .ALUControl(ALUControl), .state(state), .illegal_op(illegal_op)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [6:0]  op;
      logic [2:0]  f3;
      logic        f7, z, s, rdy;
      logic [3:0]  st;
      logic [17:0] o;
   } vec_t;

   vec_t vecs[$];

   // o = {mem_req, AdrSrc, IRWrite, PCWrite, MemWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl, illegal_op}
   function automatic vec_t mk(input logic [6:0] op_i, input logic [2:0] f3, input logic f7, z, s, rdy,
                               input logic [3:0] st, input logic mreq, adr, irw, pcw, mw, rw,
                               input logic [1:0] rs, sa, sb, imm, input logic [2:0] alu, input logic ill);
      vec_t v;
      v.op = op_i; v.f3 = f3; v.f7 = f7; v.z = z; v.s = s; v.rdy = rdy; v.st = st;
      v.o  = {mreq, adr, irw, pcw, mw, rw, rs, sa, sb, imm, alu, ill};
      return v;
   endfunction

   function automatic logic [17:0] outs();
      return {mem_req, AdrSrc, IRWrite, PCWrite, MemWrite, RegWrite, ResultSrc,
              ALUSrcA, ALUSrcB, ImmSrc, ALUControl, illegal_op};
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, got, exp);
   endtask

   initial begin
      rst_n = 1'b0; op = 7'b0000011; funct3 = 3'b010; funct7b5 = 1'b0;
      ZeroF = 1'b0; SignF = 1'b0; mem_ready = 1'b1;

      // Load with 2 FETCH stalls and 1 MEMREAD stall: 8 cycles
      vecs.push_back(mk(7'b0000011,3'b010,0,0,0,0, 0, 1,0,0,0,0,0, 2'b10,2'b00,2'b10,2'b00,3'b000,0));
      vecs.push_back(mk(7'b0000011,3'b010,0,0,0,0, 0, 1,0,0,0,0,0, 2'b10,2'b00,2'b10,2'b00,3'b000,0));
      vecs.push_back(mk(7'b0000011,3'b010,0,0,0,1, 0, 1,0,1,1,0,0, 2'b10,2'b00,2'b10,2'b00,3'b000,0));
      vecs.push_back(mk(7'b0000011,3'b010,0,0,0,1, 1, 0,0,0,0,0,0, 2'b00,2'b01,2'b01,2'b00,3'b000,0));
      vecs.push_back(mk(7'b0000011,3'b010,0,0,0,1, 2, 0,0,0,0,0,0, 2'b00,2'b10,2'b01,2'b00,3'b000,0));
      vecs.push_back(mk(7'b0000011,3'b010,0,0,0,0, 3, 1,1,0,0,0,0, 2'b00,2'b00,2'b00,2'b00,3'b000,0));
      vecs.push_back(mk(7'b0000011,3'b010,0,0,0,1, 3, 1,1,0,0,0,0, 2'b00,2'b00,2'b00,2'b00,3'b000,0));
      vecs.push_back(mk(7'b0000011,3'b010,0,0,0,1, 4, 0,0,0,0,0,1, 2'b01,2'b00,2'b00,2'b00,3'b000,0));
      // R-type sub
      vecs.push_back(mk(7'b0110011,3'b000,1,0,0,1, 0, 1,0,1,1,0,0, 2'b10,2'b00,2'b10,2'b00,3'b000,0));
      vecs.push_back(mk(7'b0110011,3'b000,1,0,0,1, 1, 0,0,0,0,0,0, 2'b00,2'b01,2'b01,2'b00,3'b000,0));
      vecs.push_back(mk(7'b0110011,3'b000,1,0,0,1, 6, 0,0,0,0,0,0, 2'b00,2'b10,2'b00,2'b00,3'b010,0));
      vecs.push_back(mk(7'b0110011,3'b000,1,0,0,1, 8, 0,0,0,0,0,1, 2'b00,2'b00,2'b00,2'b00,3'b000,0));
      // I-type with funct7b5=1 stays add
      vecs.push_back(mk(7'b0010011,3'b000,1,0,0,1, 0, 1,0,1,1,0,0, 2'b10,2'b00,2'b10,2'b00,3'b000,0));
      vecs.push_back(mk(7'b0010011,3'b000,1,0,0,1, 1, 0,0,0,0,0,0, 2'b00,2'b01,2'b01,2'b00,3'b000,0));
      vecs.push_back(mk(7'b0010011,3'b000,1,0,0,1, 7, 0,0,0,0,0,0, 2'b00,2'b10,2'b01,2'b00,3'b000,0));
      vecs.push_back(mk(7'b0010011,3'b000,1,0,0,1, 8, 0,0,0,0,0,1, 2'b00,2'b00,2'b00,2'b00,3'b000,0));
      // R-type funct3=001 and I-type funct3=101
      vecs.push_back(mk(7'b0110011,3'b001,0,0,0,1, 0, 1,0,1,1,0,0, 2'b10,2'b00,2'b10,2'b00,3'b000,0));
      vecs.push_back(mk(7'b0110011,3'b001,0,0,0,1, 1, 0,0,0,0,0,0, 2'b00,2'b01,2'b01,2'b00,3'b000,0));
      vecs.push_back(mk(7'b0110011,3'b001,0,0,0,1, 6, 0,0,0,0,0,0, 2'b00,2'b10,2'b00,2'b00,3'b001,0));
      vecs.push_back(mk(7'b0110011,3'b001,0,0,0,1, 8, 0,0,0,0,0,1, 2'b00,2'b00,2'b00,2'b00,3'b000,0));
      vecs.push_back(mk(7'b0010011,3'b101,0,0,0,1, 0, 1,0,1,1,0,0, 2'b10,2'b00,2'b10,2'b00,3'b000,0));
      vecs.push_back(mk(7'b0010011,3'b101,0,0,0,1, 1, 0,0,0,0,0,0, 2'b00,2'b01,2'b01,2'b00,3'b000,0));
      vecs.push_back(mk(7'b0010011,3'b101,0,0,0,1, 7, 0,0,0,0,0,0, 2'b00,2'b10,2'b01,2'b00,3'b101,0));
      vecs.push_back(mk(7'b0010011,3'b101,0,0,0,1, 8, 0,0,0,0,0,1, 2'b00,2'b00,2'b00,2'b00,3'b000,0));
      // beq taken
      vecs.push_back(mk(7'b1100011,3'b000,0,1,0,1, 0, 1,0,1,1,0,0, 2'b10,2'b00,2'b10,2'b10,3'b000,0));
      vecs.push_back(mk(7'b1100011,3'b000,0,1,0,1, 1, 0,0,0,0,0,0, 2'b00,2'b01,2'b01,2'b10,3'b000,0));
      vecs.push_back(mk(7'b1100011,3'b000,0,1,0,1, 9, 0,0,0,1,0,0, 2'b00,2'b10,2'b00,2'b10,3'b010,0));
      // bne not taken, mem_ready low outside memory states is ignored
      vecs.push_back(mk(7'b1100011,3'b001,0,1,0,1, 0, 1,0,1,1,0,0, 2'b10,2'b00,2'b10,2'b10,3'b000,0));
      vecs.push_back(mk(7'b1100011,3'b001,0,1,0,0, 1, 0,0,0,0,0,0, 2'b00,2'b01,2'b01,2'b10,3'b000,0));
      vecs.push_back(mk(7'b1100011,3'b001,0,1,0,0, 9, 0,0,0,0,0,0, 2'b00,2'b10,2'b00,2'b10,3'b010,0));
      // blt-style taken on SignF
      vecs.push_back(mk(7'b1100011,3'b100,0,0,1,1, 0, 1,0,1,1,0,0, 2'b10,2'b00,2'b10,2'b10,3'b000,0));
      vecs.push_back(mk(7'b1100011,3'b100,0,0,1,1, 1, 0,0,0,0,0,0, 2'b00,2'b01,2'b01,2'b10,3'b000,0));
      vecs.push_back(mk(7'b1100011,3'b100,0,0,1,1, 9, 0,0,0,1,0,0, 2'b00,2'b10,2'b00,2'b10,3'b010,0));
      // unsupported branch funct3 never writes PC
      vecs.push_back(mk(7'b1100011,3'b110,0,1,1,1, 0, 1,0,1,1,0,0, 2'b10,2'b00,2'b10,2'b10,3'b000,0));
      vecs.push_back(mk(7'b1100011,3'b110,0,1,1,1, 1, 0,0,0,0,0,0, 2'b00,2'b01,2'b01,2'b10,3'b000,0));
      vecs.push_back(mk(7'b1100011,3'b110,0,1,1,1, 9, 0,0,0,0,0,0, 2'b00,2'b10,2'b00,2'b10,3'b010,0));
      // illegal opcode: single-cycle pulse in DECODE, back to FETCH
      vecs.push_back(mk(7'b1111111,3'b000,0,0,0,1, 0, 1,0,1,1,0,0, 2'b10,2'b00,2'b10,2'b00,3'b000,0));
      vecs.push_back(mk(7'b1111111,3'b000,0,0,0,1, 1, 0,0,0,0,0,0, 2'b00,2'b01,2'b01,2'b00,3'b000,1));
      vecs.push_back(mk(7'b1111111,3'b000,0,0,0,0, 0, 1,0,0,0,0,0, 2'b10,2'b00,2'b10,2'b00,3'b000,0));
      vecs.push_back(mk(7'b1111111,3'b000,0,0,0,0, 0, 1,0,0,0,0,0, 2'b10,2'b00,2'b10,2'b00,3'b000,0));
      // store with one MEMWRITE stall
      vecs.push_back(mk(7'b0100011,3'b010,0,0,0,1, 0, 1,0,1,1,0,0, 2'b10,2'b00,2'b10,2'b01,3'b000,0));
      vecs.push_back(mk(7'b0100011,3'b010,0,0,0,1, 1, 0,0,0,0,0,0, 2'b00,2'b01,2'b01,2'b01,3'b000,0));
      vecs.push_back(mk(7'b0100011,3'b010,0,0,0,1, 2, 0,0,0,0,0,0, 2'b00,2'b10,2'b01,2'b01,3'b000,0));
      vecs.push_back(mk(7'b0100011,3'b010,0,0,0,0, 5, 1,1,0,0,1,0, 2'b00,2'b00,2'b00,2'b01,3'b000,0));
      vecs.push_back(mk(7'b0100011,3'b010,0,0,0,1, 5, 1,1,0,0,1,0, 2'b00,2'b00,2'b00,2'b01,3'b000,0));
      vecs.push_back(mk(7'b0100011,3'b010,0,0,0,0, 0, 1,0,0,0,0,0, 2'b10,2'b00,2'b10,2'b01,3'b000,0));

      // Reset state with mem_ready high: no strobes, no request
      repeat (2) @(negedge clk);
      #2;
      check("reset_state", 32'(state), 32'd0);
      check("reset_outs", 32'({mem_req, IRWrite, PCWrite, MemWrite, RegWrite}), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("release_fetch", 32'({state, mem_req}), 32'({4'd0, 1'b1}));

      foreach (vecs[i]) begin
         if (i != 0) @(negedge clk);
         op = vecs[i].op; funct3 = vecs[i].f3; funct7b5 = vecs[i].f7;
         ZeroF = vecs[i].z; SignF = vecs[i].s; mem_ready = vecs[i].rdy;
         #2;
         check($sformatf("vec%0d_state", i), 32'(state), 32'(vecs[i].st));
         check($sformatf("vec%0d_outs", i), 32'(outs()), 32'(vecs[i].o));
      end

      // Reset mid-access: load stalled in MEMREAD, rst_n asserted between clock edges
      @(negedge clk);
      op = 7'b0000011; funct3 = 3'b010; mem_ready = 1'b1;
      repeat (3) @(negedge clk);
      mem_ready = 1'b0;
      #2;
      check("memread_before_rst", 32'({state, mem_req}), 32'({4'd3, 1'b1}));
      #1 rst_n = 1'b0;
      #1;
      check("async_rst_state", 32'(state), 32'd0);
      check("async_rst_strobes", 32'({mem_req, IRWrite, PCWrite, MemWrite, RegWrite}), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("rerelease_fetch", 32'({state, mem_req}), 32'({4'd0, 1'b1}));

      // Store held in MEMWRITE, then reset pulse
      op = 7'b0100011; mem_ready = 1'b1;
      repeat (3) @(negedge clk);
      mem_ready = 1'b0;
      repeat (2) @(negedge clk);
      #2;
      check("store_held", 32'({state, MemWrite, mem_req}), 32'({4'd5, 1'b1, 1'b1}));
      #1 rst_n = 1'b0;
      #1;
      check("store_rst_memwrite", 32'(MemWrite), 32'd0);
      check("store_rst_state", 32'(state), 32'd0);
      #1 rst_n = 1'b1;
      @(negedge clk);
      #2;
      check("store_rst_stays_fetch", 32'({state, mem_req, IRWrite}), 32'({4'd0, 1'b1, 1'b0}));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
